// File: rtl/decode_stage_mc_pkg.sv
// Shared types and encodings for the registered ARM-subset decode stage.
// Holds the opcode/cmd/ALU encodings, the E-stage control bundle and the FSM state type.
package decode_pkg;

    localparam int ALU_W = 3;

    typedef enum logic [1:0] {
        DP    = 2'b00,
        MEM   = 2'b01,
        BR    = 2'b10,
        UNDEF = 2'b11
    } op_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_XOR = 4'b1101;
    localparam logic [3:0] CMD_MUL = 4'b0001;
    localparam logic [3:0] CMD_CMP = 4'b1111;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ORR = 3'b101;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'b001;
    localparam logic [ALU_W-1:0] ALU_MUL = 3'b110;
    localparam logic [ALU_W-1:0] ALU_CMP = 3'b100;

    typedef struct packed {
        logic             pcsrc;
        logic             regwrite;
        logic             memwrite;
        logic             memtoreg;
        logic             alusrc;
        logic             branch;
        logic [1:0]       immsrc;
        logic [1:0]       regsrc;
        logic [ALU_W-1:0] alucontrol;
        logic [1:0]       flagwrite;
        logic [3:0]       cond;
    } ctrl_bundle_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/decode_stage_mc_if.sv
// Decode-stage bus: instruction fields in, registered E-stage bundle out.
// The producer (master) drives the *_i signals; the decode stage (slave) drives the *_o signals.
interface decode_stage_mc_if #(
    parameter int REG_ADDR_W = 4,
    parameter int ALU_CTRL_W = 3
);
    import decode_pkg::*;

    // Handshake: an instruction transfers on a rising edge where valid_i & ready_o & ~flush_i;
    // ready_o depends only on stage state and stall_i, never on valid_i, and valid_o marks
    // a bundle that Execute must consume (no downstream back-pressure besides stall_i).
    logic                  valid_i;
    logic                  ready_o;
    logic [1:0]            op_i;
    logic [5:0]            funct_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic [3:0]            cond_i;
    logic                  stall_i;
    logic                  flush_i;

    logic                  valid_o;
    logic                  pcsrc_o;
    logic                  regwrite_o;
    logic                  memwrite_o;
    logic                  memtoreg_o;
    logic                  alusrc_o;
    logic                  branch_o;
    logic [1:0]            immsrc_o;
    logic [1:0]            regsrc_o;
    logic [ALU_CTRL_W-1:0] alucontrol_o;
    logic [1:0]            flagwrite_o;
    logic [3:0]            cond_o;
    logic                  undef_o;

    state_t                dbg_state_o;
    logic [7:0]            dbg_count_o;

    modport master (
        output valid_i, op_i, funct_i, rd_i, cond_i, stall_i, flush_i,
        input  ready_o, valid_o, pcsrc_o, regwrite_o, memwrite_o, memtoreg_o, alusrc_o,
               branch_o, immsrc_o, regsrc_o, alucontrol_o, flagwrite_o, cond_o, undef_o,
               dbg_state_o, dbg_count_o
    );

    modport slave (
        input  valid_i, op_i, funct_i, rd_i, cond_i, stall_i, flush_i,
        output ready_o, valid_o, pcsrc_o, regwrite_o, memwrite_o, memtoreg_o, alusrc_o,
               branch_o, immsrc_o, regsrc_o, alucontrol_o, flagwrite_o, cond_o, undef_o,
               dbg_state_o, dbg_count_o
    );

endinterface

// File: rtl/decode_stage_mc_main_decode_comb.sv
// Purely combinational main decoder: Op/Funct/Rd/Cond to control bundle, MUL and undef flags.
// Unknown Op or DP cmd yields undef with all write enables cleared, never X.
module main_decode_comb
    import decode_pkg::*;
#(
    parameter int                    REG_ADDR_W = 4,
    parameter logic [REG_ADDR_W-1:0] PC_REG     = '1
) (
    input  logic [1:0]            i_op,
    input  logic [5:0]            i_funct,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [3:0]            i_cond,
    output ctrl_bundle_t          o_bundle,
    output logic                  o_is_mul,
    output logic                  o_undef
);

    ctrl_bundle_t w_b;
    logic         w_alu_op;
    logic         w_undef;
    logic         w_is_mul;
    logic         w_addsub;
    logic [3:0]   w_cmd;

    assign w_cmd = i_funct[4:1];

    always_comb begin
        w_b            = '0;
        w_b.alucontrol = ALU_ADD;
        w_b.cond       = i_cond;
        w_alu_op       = 1'b0;
        w_undef        = 1'b0;
        w_is_mul       = 1'b0;
        w_addsub       = 1'b0;

        case (i_op)
            DP: begin
                w_b.regwrite = 1'b1;
                w_b.alusrc   = i_funct[5];
                w_alu_op     = 1'b1;
            end
            MEM: begin
                w_b.immsrc = 2'b01;
                w_b.alusrc = 1'b1;
                if (i_funct[0]) begin
                    w_b.memtoreg = 1'b1;
                    w_b.regwrite = 1'b1;
                end else begin
                    w_b.regsrc   = 2'b10;
                    w_b.memwrite = 1'b1;
                end
            end
            BR: begin
                w_b.regsrc = 2'b01;
                w_b.immsrc = 2'b10;
                w_b.alusrc = 1'b1;
                w_b.branch = 1'b1;
            end
            default: w_undef = 1'b1;
        endcase

        if (w_alu_op) begin
            case (w_cmd)
                CMD_ADD: begin w_b.alucontrol = ALU_ADD; w_addsub = 1'b1; end
                CMD_SUB: begin w_b.alucontrol = ALU_SUB; w_addsub = 1'b1; end
                CMD_AND: w_b.alucontrol = ALU_AND;
                CMD_ORR: w_b.alucontrol = ALU_ORR;
                CMD_XOR: w_b.alucontrol = ALU_XOR;
                CMD_MUL: begin w_b.alucontrol = ALU_MUL; w_is_mul = 1'b1; end
                CMD_CMP: w_b.alucontrol = ALU_CMP;
                default: begin
                    w_undef      = 1'b1;
                    w_b.regwrite = 1'b0;
                end
            endcase
            // Flag updates are write enables too, so an undefined cmd must not touch flags.
            w_b.flagwrite[1] = i_funct[0] & ~w_undef;
            w_b.flagwrite[0] = i_funct[0] & ~w_undef & w_addsub;
        end

        w_b.pcsrc = ((i_rd == PC_REG) & w_b.regwrite) | w_b.branch;
    end

    assign o_bundle = w_b;
    assign o_is_mul = w_is_mul;
    assign o_undef  = w_undef;

endmodule

// File: rtl/decode_stage_mc.sv
// Registered decode stage: D/E bundle register with stall/flush and MUL wait-state sequencing.
// A fired MUL parks the stage in MUL_WAIT for MUL_CYCLES-1 bubble cycles before accepting again.
module decode_stage_mc
    import decode_pkg::*;
#(
    parameter int                    MUL_CYCLES = 3,
    parameter int                    REG_ADDR_W = 4,
    parameter logic [REG_ADDR_W-1:0] PC_REG     = '1,
    parameter int                    ALU_CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_stage_mc_if.slave  bus
);

    localparam int             CNT_W    = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    ctrl_bundle_t     w_bundle;
    logic             w_is_mul;
    logic             w_undef;
    logic             w_ready;
    logic             w_fire;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    ctrl_bundle_t     r_bundle;
    logic             r_valid;
    logic             r_undef;

    main_decode_comb #(
        .REG_ADDR_W (REG_ADDR_W),
        .PC_REG     (PC_REG)
    ) u_main_decode (
        .i_op     (bus.op_i),
        .i_funct  (bus.funct_i),
        .i_rd     (bus.rd_i),
        .i_cond   (bus.cond_i),
        .o_bundle (w_bundle),
        .o_is_mul (w_is_mul),
        .o_undef  (w_undef)
    );

    assign w_ready = (r_state == IDLE) & ~bus.stall_i;
    assign w_fire  = bus.valid_i & w_ready & ~bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (bus.flush_i) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (!bus.stall_i) begin
            case (r_state)
                IDLE: begin
                    if (w_fire && w_is_mul && !w_undef && (MUL_CYCLES > 1)) begin
                        w_state_nxt = MUL_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                MUL_WAIT: begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // On flush the bundle fields keep their last value; only valid_o is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_undef  <= 1'b0;
            r_bundle <= '0;
        end else if (bus.flush_i) begin
            r_valid  <= 1'b0;
        end else if (!bus.stall_i) begin
            r_valid <= w_fire;
            if (w_fire) begin
                r_bundle <= w_bundle;
                r_undef  <= w_undef;
            end
        end
    end

    assign bus.ready_o      = w_ready;
    assign bus.valid_o      = r_valid;
    assign bus.pcsrc_o      = r_bundle.pcsrc;
    assign bus.regwrite_o   = r_bundle.regwrite;
    assign bus.memwrite_o   = r_bundle.memwrite;
    assign bus.memtoreg_o   = r_bundle.memtoreg;
    assign bus.alusrc_o     = r_bundle.alusrc;
    assign bus.branch_o     = r_bundle.branch;
    assign bus.immsrc_o     = r_bundle.immsrc;
    assign bus.regsrc_o     = r_bundle.regsrc;
    assign bus.alucontrol_o = ALU_CTRL_W'(r_bundle.alucontrol);
    assign bus.flagwrite_o  = r_bundle.flagwrite;
    assign bus.cond_o       = r_bundle.cond;
    assign bus.undef_o      = r_undef;
    assign bus.dbg_state_o  = r_state;
    assign bus.dbg_count_o  = 8'(r_cnt);

endmodule

// File: tb/tb_decode_stage_mc.sv
// Directed bench for decode_stage_mc: decode table, MUL wait states, stall, flush, undef, async reset.
// Expected values are hand-derived from the decode table and MUL_CYCLES=3 timing.
module tb_decode_stage_mc;
    import decode_pkg::*;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    decode_stage_mc_if #(.REG_ADDR_W(4), .ALU_CTRL_W(3)) bus ();

    decode_stage_mc #(
        .MUL_CYCLES (3),
        .REG_ADDR_W (4),
        .PC_REG     (4'b1111),
        .ALU_CTRL_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input logic [3:0] c);
        bus.valid_i = v;
        bus.op_i    = op;
        bus.funct_i = f;
        bus.rd_i    = rd;
        bus.cond_i  = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {12'b0, bus.pcsrc_o, bus.regwrite_o, bus.memwrite_o, bus.memtoreg_o,
                bus.alusrc_o, bus.branch_o, bus.immsrc_o, bus.regsrc_o, bus.alucontrol_o,
                bus.flagwrite_o, bus.cond_o, bus.undef_o};
    endfunction

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, 2'b00, 6'b000000, 4'd0, 4'd0);
        #3;
        chk("reset_valid", 32'(bus.valid_o), 32'd0);
        chk("reset_ready", 32'(bus.ready_o), 32'd1);
        chk("reset_outs", all_outs(), 32'd0);
        chk("reset_state", 32'(bus.dbg_state_o), 32'(IDLE));
        chk("reset_count", 32'(bus.dbg_count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDS with immediate, rd=3
        drive(1'b1, 2'b00, 6'b101001, 4'd3, 4'b1110);
        step();
        chk("adds_valid", 32'(bus.valid_o), 32'd1);
        chk("adds_alu", 32'(bus.alucontrol_o), 32'b011);
        chk("adds_flagw", 32'(bus.flagwrite_o), 32'b11);
        chk("adds_regw", 32'(bus.regwrite_o), 32'd1);
        chk("adds_alusrc", 32'(bus.alusrc_o), 32'd1);
        chk("adds_pcsrc", 32'(bus.pcsrc_o), 32'd0);
        chk("adds_cond", 32'(bus.cond_o), 32'b1110);
        chk("adds_undef", 32'(bus.undef_o), 32'd0);
        drive(1'b0, 2'b00, 6'b000000, 4'd0, 4'd0);
        step();
        chk("bubble_valid", 32'(bus.valid_o), 32'd0);

        // MUL followed by ADD with valid_i held high
        drive(1'b1, 2'b00, 6'b000010, 4'd5, 4'b1110);
        step();
        chk("mul_valid", 32'(bus.valid_o), 32'd1);
        chk("mul_alu", 32'(bus.alucontrol_o), 32'b110);
        chk("mul_ready0", 32'(bus.ready_o), 32'd0);
        chk("mul_count0", 32'(bus.dbg_count_o), 32'd2);
        drive(1'b1, 2'b00, 6'b001000, 4'd2, 4'b1110);
        step();
        chk("mulw1_valid", 32'(bus.valid_o), 32'd0);
        chk("mulw1_ready", 32'(bus.ready_o), 32'd0);
        chk("mulw1_count", 32'(bus.dbg_count_o), 32'd1);
        step();
        chk("mulw2_valid", 32'(bus.valid_o), 32'd0);
        chk("mulw2_ready", 32'(bus.ready_o), 32'd1);
        step();
        chk("add_after_mul_valid", 32'(bus.valid_o), 32'd1);
        chk("add_after_mul_alu", 32'(bus.alucontrol_o), 32'b011);
        chk("add_after_mul_flagw", 32'(bus.flagwrite_o), 32'b00);
        drive(1'b0, 2'b00, 6'b000000, 4'd0, 4'd0);
        step();

        // Stall for two cycles during MUL_WAIT
        drive(1'b1, 2'b00, 6'b000010, 4'd6, 4'b0000);
        step();
        chk("smul_valid", 32'(bus.valid_o), 32'd1);
        drive(1'b0, 2'b00, 6'b000000, 4'd0, 4'd0);
        bus.stall_i = 1'b1;
        step();
        chk("stall1_valid", 32'(bus.valid_o), 32'd1);
        chk("stall1_alu", 32'(bus.alucontrol_o), 32'b110);
        chk("stall1_count", 32'(bus.dbg_count_o), 32'd2);
        step();
        chk("stall2_count", 32'(bus.dbg_count_o), 32'd2);
        chk("stall2_state", 32'(bus.dbg_state_o), 32'(MUL_WAIT));
        bus.stall_i = 1'b0;
        step();
        chk("unstall1_valid", 32'(bus.valid_o), 32'd0);
        chk("unstall1_count", 32'(bus.dbg_count_o), 32'd1);
        chk("unstall1_ready", 32'(bus.ready_o), 32'd0);
        step();
        chk("unstall2_ready", 32'(bus.ready_o), 32'd1);
        chk("unstall2_state", 32'(bus.dbg_state_o), 32'(IDLE));

        // Flush while in MUL_WAIT, with an instruction presented
        drive(1'b1, 2'b00, 6'b000010, 4'd7, 4'b0000);
        step();
        chk("fmul_state", 32'(bus.dbg_state_o), 32'(MUL_WAIT));
        drive(1'b1, 2'b00, 6'b001000, 4'd2, 4'b0000);
        bus.flush_i = 1'b1;
        step();
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        chk("flush_ready", 32'(bus.ready_o), 32'd1);
        chk("flush_state", 32'(bus.dbg_state_o), 32'(IDLE));
        chk("flush_count", 32'(bus.dbg_count_o), 32'd0);
        bus.flush_i = 1'b0;
        drive(1'b0, 2'b00, 6'b000000, 4'd0, 4'd0);
        step();
        chk("postflush_valid", 32'(bus.valid_o), 32'd0);
        // Flush in IDLE must block a valid instruction
        drive(1'b1, 2'b00, 6'b001000, 4'd2, 4'b0000);
        bus.flush_i = 1'b1;
        step();
        chk("flush_idle_valid", 32'(bus.valid_o), 32'd0);
        bus.flush_i = 1'b0;

        // Op=11 undefined, with rd=PC and all funct bits set
        drive(1'b1, 2'b11, 6'b111111, 4'd15, 4'b1010);
        step();
        chk("op11_valid", 32'(bus.valid_o), 32'd1);
        chk("op11_undef", 32'(bus.undef_o), 32'd1);
        chk("op11_regw", 32'(bus.regwrite_o), 32'd0);
        chk("op11_memw", 32'(bus.memwrite_o), 32'd0);
        chk("op11_pcsrc", 32'(bus.pcsrc_o), 32'd0);
        chk("op11_branch", 32'(bus.branch_o), 32'd0);
        chk("op11_flagw", 32'(bus.flagwrite_o), 32'd0);
        chk("op11_cond", 32'(bus.cond_o), 32'b1010);
        chk("op11_noX", 32'(^all_outs() === 1'bx), 32'd0);
        chk("op11_ready", 32'(bus.ready_o), 32'd1);

        // DP with unsupported cmd 0110, S=1, rd=PC
        drive(1'b1, 2'b00, 6'b001101, 4'd15, 4'b0001);
        step();
        chk("cmd6_valid", 32'(bus.valid_o), 32'd1);
        chk("cmd6_undef", 32'(bus.undef_o), 32'd1);
        chk("cmd6_regw", 32'(bus.regwrite_o), 32'd0);
        chk("cmd6_memw", 32'(bus.memwrite_o), 32'd0);
        chk("cmd6_pcsrc", 32'(bus.pcsrc_o), 32'd0);
        chk("cmd6_flagw", 32'(bus.flagwrite_o), 32'd0);
        chk("cmd6_noX", 32'(^all_outs() === 1'bx), 32'd0);
        chk("cmd6_ready", 32'(bus.ready_o), 32'd1);

        // Branch
        drive(1'b1, 2'b10, 6'b000000, 4'd0, 4'b0000);
        step();
        chk("b_pcsrc", 32'(bus.pcsrc_o), 32'd1);
        chk("b_branch", 32'(bus.branch_o), 32'd1);
        chk("b_regsrc", 32'(bus.regsrc_o), 32'b01);
        chk("b_immsrc", 32'(bus.immsrc_o), 32'b10);
        chk("b_alusrc", 32'(bus.alusrc_o), 32'd1);
        chk("b_regw", 32'(bus.regwrite_o), 32'd0);
        chk("b_undef", 32'(bus.undef_o), 32'd0);

        // ADD with rd=PC
        drive(1'b1, 2'b00, 6'b001000, 4'd15, 4'b1110);
        step();
        chk("addpc_pcsrc", 32'(bus.pcsrc_o), 32'd1);
        chk("addpc_regw", 32'(bus.regwrite_o), 32'd1);
        chk("addpc_alusrc", 32'(bus.alusrc_o), 32'd0);

        // SUBS, CMPS, ORR, XOR, AND
        drive(1'b1, 2'b00, 6'b000101, 4'd1, 4'b1110);
        step();
        chk("subs_alu", 32'(bus.alucontrol_o), 32'b010);
        chk("subs_flagw", 32'(bus.flagwrite_o), 32'b11);
        chk("subs_pcsrc", 32'(bus.pcsrc_o), 32'd0);
        drive(1'b1, 2'b00, 6'b011111, 4'd1, 4'b1110);
        step();
        chk("cmps_alu", 32'(bus.alucontrol_o), 32'b100);
        chk("cmps_flagw", 32'(bus.flagwrite_o), 32'b10);
        drive(1'b1, 2'b00, 6'b011000, 4'd1, 4'b1110);
        step();
        chk("orr_alu", 32'(bus.alucontrol_o), 32'b101);
        drive(1'b1, 2'b00, 6'b011010, 4'd1, 4'b1110);
        step();
        chk("xor_alu", 32'(bus.alucontrol_o), 32'b001);
        drive(1'b1, 2'b00, 6'b000000, 4'd1, 4'b1110);
        step();
        chk("and_alu", 32'(bus.alucontrol_o), 32'b000);

        // LDR and STR
        drive(1'b1, 2'b01, 6'b000001, 4'd4, 4'b1110);
        step();
        chk("ldr_memtoreg", 32'(bus.memtoreg_o), 32'd1);
        chk("ldr_regw", 32'(bus.regwrite_o), 32'd1);
        chk("ldr_immsrc", 32'(bus.immsrc_o), 32'b01);
        chk("ldr_regsrc", 32'(bus.regsrc_o), 32'b00);
        chk("ldr_memw", 32'(bus.memwrite_o), 32'd0);
        chk("ldr_alu", 32'(bus.alucontrol_o), 32'b011);
        drive(1'b1, 2'b01, 6'b000000, 4'd4, 4'b1110);
        step();
        chk("str_memw", 32'(bus.memwrite_o), 32'd1);
        chk("str_regw", 32'(bus.regwrite_o), 32'd0);
        chk("str_regsrc", 32'(bus.regsrc_o), 32'b10);
        chk("str_alusrc", 32'(bus.alusrc_o), 32'd1);

        // Asynchronous reset in the middle of MUL_WAIT
        drive(1'b1, 2'b00, 6'b000010, 4'd8, 4'b1110);
        step();
        chk("rmul_valid", 32'(bus.valid_o), 32'd1);
        drive(1'b0, 2'b00, 6'b000000, 4'd0, 4'd0);
        step();
        chk("rmul_count", 32'(bus.dbg_count_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", all_outs(), 32'd0);
        chk("arst_valid", 32'(bus.valid_o), 32'd0);
        chk("arst_ready", 32'(bus.ready_o), 32'd1);
        chk("arst_state", 32'(bus.dbg_state_o), 32'(IDLE));
        chk("arst_count", 32'(bus.dbg_count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.valid_o), 32'd0);
        chk("post_rst_ready", 32'(bus.ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
